srl_fifo_ctrl: RTL and testbench
================================

// Module: srl_fifo_ctrl
// PURPOSE
//  Ready/valid FIFO built on an addressable shift-register array (16-deep SRL style).
//  Every accepted write shifts into tap 0. The read side tracks occupancy and addresses the oldest tap.
//  Used as a cheap, shallow elastic buffer between streaming datapath stages.
// PARAMETERS
//  WIDTH  18  data width in bits
//  DEPTH  16  array capacity in entries; legal 2..16 (4-bit tap address)
// PORTS
//  clk       in   1      single clock; all logic is rising-edge
//  rst_n     in   1      asynchronous, active-low reset
//  clear     in   1      synchronous flush; count goes to 0
//  i_tdata   in   WIDTH  write data
//  i_tvalid  in   1      write request
//  i_tready  out  1      FIFO can accept a write
//  o_tdata   out  WIDTH  oldest entry
//  o_tvalid  out  1      o_tdata holds a valid entry
//  o_tready  in   1      consumer accepts o_tdata
//  occupied  out  5      entries held, including the output register when it is enabled
//  space     out  5      CAPACITY - occupied
// BEHAVIOUR
//  push = i_tvalid & i_tready.
//  pop  = o_tvalid & o_tready.
//  Array contents are not reset; only the control state is reset.
//  Array: on push, tap k takes tap k-1 for k=1..DEPTH-1, and tap 0 takes i_tdata.
//  cnt: array occupancy, 0..DEPTH, 5 bits.
//   - Updates as +1 on push only, -1 on array read only, and is unchanged when both or neither occur.
//  i_tready = (cnt != DEPTH).
//   - Full with a simultaneous pop: still not ready; there is no full pass-through.
//  Read tap address = cnt-1, truncated to 4 bits; don't-care when cnt==0.
//   - Push and pop together: cnt stays the same and the shift moves the next-oldest entry onto the same address.
//  Empty: o_tvalid=0; o_tready is ignored; no underflow.
//  clear: cnt:=0 and output register invalidated on the next edge.
//   - clear overrides push and pop in that cycle.
//   - i_tready stays at its normal value; a push accepted in the clear cycle is discarded.
//  rst_n low, asynchronous and possibly mid-transfer:
//   - cnt=0, output register invalid.
//   - o_tvalid=0, i_tready=1, occupied=0, space=CAPACITY immediately.
//   - Operation resumes on the first edge after rst_n deasserts.
//  Reset values: o_tvalid=0, i_tready=1, occupied=0, space=CAPACITY.
//   - o_tdata is undefined when o_tvalid=0.
// CONFIGURATION
//  SRL_FIFO_OUTREG_EN undefined:
//   - CAPACITY=DEPTH.
//   - o_tdata is the combinational array tap; o_tvalid=(cnt!=0); array read = pop.
//   - Latency: the push edge gives o_tvalid=1 in the next cycle (1 cycle).
//  SRL_FIFO_OUTREG_EN defined:
//   - Adds a WIDTH-bit output register plus a valid flop; CAPACITY=DEPTH+1.
//   - Register loads from the tap when (cnt!=0) & (~reg_valid | pop); that load is the array read.
//   - o_tdata/o_tvalid come straight from flops.
//   - Latency: 2 cycles from push to o_tvalid.
//   - Pop with the array empty clears reg_valid.
// STRUCTURE
//  srl_fifo_pkg:
//   - SRL_MAX_DEPTH=16, SRL_ADDR_W=4, SRL_CNT_W=5.
//   - srl_cnt_t typedef for cnt, occupied and space.
//  Sub-module srl_shift_array (WIDTH, DEPTH):
//   - Ports: clk, shift_en, d, addr[3:0], q.
//   - No reset; one SRL16-style column per bit.
//  srl_fifo_ctrl holds cnt, the ready/valid logic and the optional output register.
// TESTING
//  Run every test with the macro undefined and again with it defined.
//  1 Reset:
//   - Drive rst_n=0 mid-stream.
//   - Check o_tvalid=0, i_tready=1, occupied=0, space=16 (17 with macro) asynchronously, before any clk edge.
//  2 Fill/drain:
//   - Push 0x00001..0x00010 with o_tready=0.
//   - i_tready drops after the 16th push (macro: the 17th; push 0x00011).
//   - Then o_tready=1: data emerges in order, one per cycle, and o_tvalid=0 afterwards.
//  3 Simultaneous push/pop:
//   - Hold cnt=5 and do push+pop for 100 cycles.
//   - occupied stays 5 and the output matches a scoreboard with no loss or duplication.
//  4 Latency:
//   - Single push of 0x2A5A5 into an empty FIFO.
//   - o_tvalid rises 1 cycle later (2 with macro) with o_tdata=0x2A5A5.
//  5 Clear:
//   - At occupied=9, assert clear together with i_tvalid and o_tready.
//   - Next cycle: occupied=0, o_tvalid=0, and the push in the clear cycle is lost.
//  6 Random:
//   - 10k cycles of random i_tvalid/o_tready at DEPTH=2 and DEPTH=16.
//   - Scoreboard matches, occupied+space==CAPACITY every cycle, and no push is accepted while full.

Source files
------------

// File: rtl/srl_fifo_pkg.sv
// srl_fifo_pkg: shared sizing constants and the count type for the SRL FIFO.
//   SRL_MAX_DEPTH : deepest supported shift-register column (SRL16)
//   SRL_ADDR_W    : tap address width
//   SRL_CNT_W     : width of cnt / occupied / space (holds 0..DEPTH+1)
package srl_fifo_pkg;

  localparam int unsigned SRL_MAX_DEPTH = 16;
  localparam int unsigned SRL_ADDR_W    = 4;
  localparam int unsigned SRL_CNT_W     = 5;

  typedef logic [SRL_CNT_W-1:0] srl_cnt_t;

  // Occupancy step: +1 on write only, -1 on read only, hold otherwise.
  function automatic srl_cnt_t srl_cnt_step(input srl_cnt_t cnt,
                                            input logic     inc,
                                            input logic     dec);
    srl_cnt_t nxt;
    nxt = cnt;
    unique case ({inc, dec})
      2'b10:   nxt = srl_cnt_t'(cnt + 1'b1);
      2'b01:   nxt = srl_cnt_t'(cnt - 1'b1);
      default: nxt = cnt;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/srl_fifo_ctrl_shift_array.sv
// srl_shift_array: addressable shift-register array, one SRL16-style column
// per data bit. No reset; contents are only meaningful under the controller.
//   clk      : rising-edge clock
//   shift_en : shift d into tap 0, tap k takes tap k-1
//   d        : write data
//   addr     : tap address for the combinational read port
//   q        : contents of tap addr
module srl_shift_array
  import srl_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  shift_en,
  input  logic [WIDTH-1:0]      d,
  input  logic [SRL_ADDR_W-1:0] addr,
  output logic [WIDTH-1:0]      q
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] taps_q [DEPTH];
  logic [WIDTH-1:0] taps_d [DEPTH];

  always_comb begin
    taps_d = taps_q;
    if (shift_en) begin
      taps_d[0] = d;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        taps_d[k] = taps_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    taps_q <= taps_d;
  end

  assign q = taps_q[addr[IDX_W-1:0]];

endmodule

// File: rtl/srl_fifo_ctrl.sv
// srl_fifo_ctrl: ready/valid FIFO on an addressable shift-register array.
// Writes always shift into tap 0; the read side addresses tap cnt-1 (oldest).
// Optional output register selected by `define SRL_FIFO_OUTREG_EN
// (adds one entry of capacity and one cycle of latency).
//   clk, rst_n        : clock, asynchronous active-low reset
//   clear             : synchronous flush (overrides push/pop)
//   i_tdata/i_tvalid/i_tready : write side
//   o_tdata/o_tvalid/o_tready : read side
//   occupied / space  : entries held / CAPACITY - occupied
module srl_fifo_ctrl
  import srl_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [WIDTH-1:0]     i_tdata,
  input  logic                 i_tvalid,
  output logic                 i_tready,
  output logic [WIDTH-1:0]     o_tdata,
  output logic                 o_tvalid,
  input  logic                 o_tready,
  output logic [SRL_CNT_W-1:0] occupied,
  output logic [SRL_CNT_W-1:0] space
);

  localparam srl_cnt_t DEPTH_C = srl_cnt_t'(DEPTH);
`ifdef SRL_FIFO_OUTREG_EN
  localparam srl_cnt_t CAPACITY_C = srl_cnt_t'(DEPTH + 1);
`else
  localparam srl_cnt_t CAPACITY_C = srl_cnt_t'(DEPTH);
`endif

  srl_cnt_t              cnt_q, cnt_d;
  logic                  push, pop, arr_rd, arr_nonempty;
  logic [SRL_ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]      tap;

  assign arr_nonempty = (cnt_q != '0);
  assign i_tready     = (cnt_q != DEPTH_C);
  assign push         = i_tvalid & i_tready;
  assign pop          = o_tvalid & o_tready;
  assign rd_addr      = SRL_ADDR_W'(cnt_q - 1'b1);

  srl_shift_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_array (
    .clk      (clk),
    .shift_en (push),
    .d        (i_tdata),
    .addr     (rd_addr),
    .q        (tap)
  );

`ifdef SRL_FIFO_OUTREG_EN
  logic             reg_valid_q, reg_valid_d;
  logic [WIDTH-1:0] reg_data_q, reg_data_d;

  // The array is read whenever the output register is empty or being drained.
  assign arr_rd = arr_nonempty & (~reg_valid_q | pop);

  always_comb begin
    reg_valid_d = reg_valid_q;
    reg_data_d  = reg_data_q;
    if (clear) begin
      reg_valid_d = 1'b0;
    end else if (arr_rd) begin
      reg_valid_d = 1'b1;
      reg_data_d  = tap;
    end else if (pop) begin
      reg_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_valid_q <= 1'b0;
    end else begin
      reg_valid_q <= reg_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    reg_data_q <= reg_data_d;
  end

  assign o_tvalid = reg_valid_q;
  assign o_tdata  = reg_data_q;
  assign occupied = srl_cnt_t'(cnt_q + {{(SRL_CNT_W-1){1'b0}}, reg_valid_q});
`else
  assign arr_rd   = pop;
  assign o_tvalid = arr_nonempty;
  assign o_tdata  = tap;
  assign occupied = cnt_q;
`endif

  assign space = srl_cnt_t'(CAPACITY_C - occupied);

  always_comb begin
    cnt_d = srl_cnt_step(cnt_q, push, arr_rd);
    if (clear) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// tb_srl_fifo_ctrl: directed and random checks of srl_fifo_ctrl at DEPTH=16
// (instance 0) and DEPTH=2 (instance 1) against a queue-based model.
// Build with and without SRL_FIFO_OUTREG_EN.
module tb_srl_fifo_ctrl;

`ifdef SRL_FIFO_OUTREG_EN
  localparam int OREG = 1;
`else
  localparam int OREG = 0;
`endif
  localparam int CAP0 = 16 + OREG;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0]       tv  = '0;
  logic [1:0]       tr  = '0;
  logic [1:0]       clr = '0;
  logic [1:0][17:0] td  = '0;
  logic [1:0]       itr, ov;
  logic [1:0][17:0] od;
  logic [1:0][4:0]  occ, spc;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  srl_fifo_ctrl #(.WIDTH(18), .DEPTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .clear(clr[0]),
    .i_tdata(td[0]), .i_tvalid(tv[0]), .i_tready(itr[0]),
    .o_tdata(od[0]), .o_tvalid(ov[0]), .o_tready(tr[0]),
    .occupied(occ[0]), .space(spc[0])
  );

  srl_fifo_ctrl #(.WIDTH(18), .DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clr[1]),
    .i_tdata(td[1]), .i_tvalid(tv[1]), .i_tready(itr[1]),
    .o_tdata(od[1]), .o_tvalid(ov[1]), .o_tready(tr[1]),
    .occupied(occ[1]), .space(spc[1])
  );

  // ---------------- behavioural model: ring-buffer queue + output slot
  logic [17:0] mbuf [2][32];
  int          mhead [2] = '{0, 0};
  int          mcnt  [2] = '{0, 0};
  bit          mrv   [2] = '{0, 0};
  logic [17:0] mrd   [2];

  function automatic int dep(input int k);
    return (k == 0) ? 16 : 2;
  endfunction

  function automatic int cap(input int k);
    return dep(k) + OREG;
  endfunction

  function automatic bit m_valid(input int k);
    return (OREG != 0) ? mrv[k] : (mcnt[k] > 0);
  endfunction

  function automatic logic [17:0] m_data(input int k);
    return (OREG != 0) ? mrd[k] : mbuf[k][mhead[k]];
  endfunction

  function automatic int m_occ(input int k);
    return mcnt[k] + ((OREG != 0 && mrv[k]) ? 1 : 0);
  endfunction

  task automatic m_step(input int k);
    bit push, pop, load;
    push = tv[k] && (mcnt[k] < dep(k));
    pop  = m_valid(k) && tr[k];
    load = (OREG != 0) && (mcnt[k] > 0) && (!mrv[k] || pop);
    if (clr[k]) begin
      mcnt[k] = 0;
      mrv[k]  = 0;
    end else begin
      if (OREG != 0) begin
        if (load) begin
          mrd[k]   = mbuf[k][mhead[k]];
          mrv[k]   = 1;
          mhead[k] = (mhead[k] + 1) % 32;
          mcnt[k]--;
        end else if (pop) begin
          mrv[k] = 0;
        end
      end else if (pop) begin
        mhead[k] = (mhead[k] + 1) % 32;
        mcnt[k]--;
      end
      if (push) begin
        mbuf[k][(mhead[k] + mcnt[k]) % 32] = td[k];
        mcnt[k]++;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          mcnt[k] = 0;
          mhead[k] = 0;
          mrv[k] = 0;
        end else begin
          m_step(k);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- compare process: every falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("u%0d_valid", k), 32'(ov[k]), 32'(m_valid(k)));
          chk($sformatf("u%0d_ready", k), 32'(itr[k]), 32'(mcnt[k] < dep(k)));
          chk($sformatf("u%0d_occupied", k), 32'(occ[k]), 32'(m_occ(k)));
          chk($sformatf("u%0d_space", k), 32'(spc[k]), 32'(cap(k) - m_occ(k)));
          chk($sformatf("u%0d_occ_plus_space", k), 32'(occ[k]) + 32'(spc[k]), 32'(cap(k)));
          if (m_valid(k)) begin
            chk($sformatf("u%0d_data", k), 32'(od[k]), 32'(m_data(k)));
          end
        end
      end
    end
  end

  // ---------------- stimulus
  initial begin
    int pv, pr;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    chk("reset_valid", 32'(ov[0]), 32'd0);
    chk("reset_space", 32'(spc[0]), 32'(CAP0));

    // Fill with consumer stalled, then drain in order.
    for (int i = 1; i <= CAP0; i++) begin
      tv[0] = 1'b1;
      td[0] = 18'(i);
      chk("fill_ready", 32'(itr[0]), 32'd1);
      @(negedge clk);
    end
    tv[0] = 1'b0;
    chk("full_ready", 32'(itr[0]), 32'd0);
    chk("full_occ", 32'(occ[0]), 32'(CAP0));
    tr[0] = 1'b1;
    for (int i = 1; i <= CAP0; i++) begin
      chk("drain_valid", 32'(ov[0]), 32'd1);
      chk("drain_data", 32'(od[0]), 32'(i));
      @(negedge clk);
    end
    tr[0] = 1'b0;
    chk("drain_empty", 32'(ov[0]), 32'd0);

    // Latency of a single write into an empty FIFO.
    tv[0] = 1'b1;
    td[0] = 18'h2A5A5;
    @(posedge clk);
    #1 tv[0] = 1'b0;
    if (OREG != 0) begin
      chk("lat_early", 32'(ov[0]), 32'd0);
      @(posedge clk);
      #1;
    end
    chk("lat_valid", 32'(ov[0]), 32'd1);
    chk("lat_data", 32'(od[0]), 32'h2A5A5);
    tr[0] = 1'b1;
    @(posedge clk);
    #1 tr[0] = 1'b0;
    chk("lat_drained", 32'(ov[0]), 32'd0);
    @(negedge clk);

    // Hold occupancy at 5 with push+pop every cycle.
    for (int i = 0; i < 5; i++) begin
      tv[0] = 1'b1;
      td[0] = 18'($urandom);
      @(negedge clk);
    end
    tv[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("hold_occ_init", 32'(occ[0]), 32'd5);
    tv[0] = 1'b1;
    tr[0] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      td[0] = 18'($urandom);
      @(negedge clk);
      chk("hold_occ", 32'(occ[0]), 32'd5);
    end
    tv[0] = 1'b0;
    repeat (8) @(negedge clk);
    tr[0] = 1'b0;
    chk("hold_drained", 32'(occ[0]), 32'd0);

    // Clear at occupancy 9 with a simultaneous write and read.
    for (int i = 0; i < 9; i++) begin
      tv[0] = 1'b1;
      td[0] = 18'(32'h100 + i);
      @(negedge clk);
    end
    tv[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("clear_pre_occ", 32'(occ[0]), 32'd9);
    clr[0] = 1'b1;
    tv[0] = 1'b1;
    tr[0] = 1'b1;
    td[0] = 18'h3FFFF;
    @(negedge clk);
    clr[0] = 1'b0;
    tv[0] = 1'b0;
    tr[0] = 1'b0;
    chk("clear_occ", 32'(occ[0]), 32'd0);
    chk("clear_valid", 32'(ov[0]), 32'd0);
    @(negedge clk);
    chk("clear_push_lost", 32'(occ[0]), 32'd0);

    // Asynchronous reset in the middle of a write stream.
    for (int i = 0; i < 3; i++) begin
      tv[0] = 1'b1;
      td[0] = 18'(32'h200 + i);
      @(negedge clk);
    end
    chk("pre_reset_occ", 32'(occ[0]), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(ov[0]), 32'd0);
    chk("arst_ready", 32'(itr[0]), 32'd1);
    chk("arst_occ", 32'(occ[0]), 32'd0);
    chk("arst_space", 32'(spc[0]), 32'(CAP0));
    tv[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Random traffic on both depths with shifting bias.
    for (int c = 0; c < 10000; c++) begin
      if (c % 500 == 0) begin
        pv = $urandom_range(10, 90);
        pr = $urandom_range(10, 90);
      end
      for (int k = 0; k < 2; k++) begin
        tv[k]  = ($urandom_range(0, 99) < pv);
        tr[k]  = ($urandom_range(0, 99) < pr);
        td[k]  = 18'($urandom);
        clr[k] = ($urandom_range(0, 255) == 0);
      end
      @(negedge clk);
    end
    tv  = '0;
    tr  = '0;
    clr = '0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
